periph_bus: RTL and testbench

Memory-mapped bus decoder and peripheral register file that sits between the CPU load/store path and the data memory. It converts CPU byte addresses into data memory word indices and owns the on-chip peripherals: a 32-bit reloading timer with interrupt, LED, switch, 7-segment and system-tick registers. It returns one read word and one `accessable` flag to the CPU, which raises an address exception when the flag is 0.

---
 rtl/periph_bus.sv | 121 ++++++++++++
 tb/tb_periph_bus.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/periph_bus.sv
// Memory-mapped bus decoder: routes CPU accesses to data memory or the
// on-chip peripheral registers (reloading timer, LED, switch, 7-seg, systick).
module periph_bus #(
  parameter int unsigned RAM_SIZE = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        accessable,
  output logic        irqout,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_accessable,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi
);

  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] RAM_BYTES = DW'(RAM_SIZE * 4);
  localparam logic [DW-1:0] ADDR_TH   = 32'h4000_0000;
  localparam logic [DW-1:0] ADDR_TL   = 32'h4000_0004;
  localparam logic [DW-1:0] ADDR_TCON = 32'h4000_0008;
  localparam logic [DW-1:0] ADDR_LED  = 32'h4000_000C;
  localparam logic [DW-1:0] ADDR_SW   = 32'h4000_0010;
  localparam logic [DW-1:0] ADDR_DIGI = 32'h4000_0014;
  localparam logic [DW-1:0] ADDR_TICK = 32'h4000_0018;

  logic [DW-1:0] th, tl, systick;
  logic [2:0]    tcon;
  logic          ram_hit, per_hit;
  logic [DW-1:0] per_val;
  logic          we_th, we_tl, we_tcon, we_led, we_digi;
  logic          overflow, irq_set;
  logic [DW-1:0] tl_next;
  logic [2:0]    tcon_next;

  assign ram_hit = (addr[1:0] == 2'b00) && (addr < RAM_BYTES);

  // Peripheral read mux; exact address match implies alignment.
  always_comb begin
    per_hit = 1'b1;
    per_val = '0;
    case (addr)
      ADDR_TH:   per_val = th;
      ADDR_TL:   per_val = tl;
      ADDR_TCON: per_val = {29'b0, tcon};
      ADDR_LED:  per_val = {24'b0, led};
      ADDR_SW:   per_val = {24'b0, switch};
      ADDR_DIGI: per_val = {20'b0, digi};
      ADDR_TICK: per_val = systick;
      default:   per_hit = 1'b0;
    endcase
  end

  always_comb begin
    rdata      = '0;
    accessable = 1'b1;
    if (rd || wr) begin
      if (ram_hit)      accessable = dm_accessable;
      else if (per_hit) accessable = 1'b1;
      else              accessable = 1'b0;
    end
    if (rd) begin
      if (ram_hit)      rdata = dm_rdata;
      else if (per_hit) rdata = per_val;
    end
  end

  assign dm_rd    = rd && ram_hit;
  assign dm_wr    = wr && ram_hit;
  assign dm_addr  = {2'b00, addr[31:2]};
  assign dm_wdata = wdata;

  assign we_th   = wr && (addr == ADDR_TH);
  assign we_tl   = wr && (addr == ADDR_TL);
  assign we_tcon = wr && (addr == ADDR_TCON);
  assign we_led  = wr && (addr == ADDR_LED);
  assign we_digi = wr && (addr == ADDR_DIGI);

  // Timer: CPU write to TL beats count/reload; a coincident overflow still sets TCON[2].
  assign overflow = tcon[0] && (tl == '1);
  assign irq_set  = overflow && tcon[1];

  always_comb begin
    tl_next = tl;
    if (we_tl)         tl_next = wdata;
    else if (overflow) tl_next = th;
    else if (tcon[0])  tl_next = tl + DW'(1);
    tcon_next = {tcon[2] | irq_set, tcon[1:0]};
    if (we_tcon)       tcon_next = {wdata[2] | irq_set, wdata[1:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      led     <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      if (we_th)   th   <= wdata;
      if (we_led)  led  <= wdata[7:0];
      if (we_digi) digi <= wdata[11:0];
      tl      <= tl_next;
      tcon    <= tcon_next;
      systick <= systick + DW'(1);
    end
  end

  assign irqout = tcon[2];

endmodule

// File: tb/tb_periph_bus.sv
// Directed self-checking bench for periph_bus.
module tb_periph_bus;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        accessable, irqout;
  logic        dm_rd, dm_wr;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_accessable;
  logic [7:0]  switch, led;
  logic [11:0] digi;

  int total = 0;
  int bad   = 0;
  logic [31:0] s0;

  always #5 clk = ~clk;

  periph_bus #(.RAM_SIZE(256)) dut (
    .clk(clk), .reset_n(reset_n), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .accessable(accessable), .irqout(irqout),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_accessable(dm_accessable),
    .switch(switch), .led(led), .digi(digi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Combinational read: check rdata and accessable, then return bus to idle.
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp,
                        input logic exp_acc);
    rd = 1'b1; wr = 1'b0; addr = a;
    #1;
    check(tag, rdata, exp);
    check({tag, "_acc"}, 32'(accessable), 32'(exp_acc));
    rd = 1'b0;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    dm_rdata = 32'h1234_5678; dm_accessable = 1'b1; switch = 8'h5C;
    tick(2);

    // Reset state, read while reset is still asserted so systick is 0.
    rd_chk("rst_th",   32'h4000_0000, 32'h0, 1'b1);
    rd_chk("rst_tl",   32'h4000_0004, 32'h0, 1'b1);
    rd_chk("rst_tcon", 32'h4000_0008, 32'h0, 1'b1);
    rd_chk("rst_led",  32'h4000_000C, 32'h0, 1'b1);
    rd_chk("rst_sw",   32'h4000_0010, 32'h5C, 1'b1);
    rd_chk("rst_digi", 32'h4000_0014, 32'h0, 1'b1);
    rd_chk("rst_tick", 32'h4000_0018, 32'h0, 1'b1);
    check("rst_irq", 32'(irqout), 32'h0);
    reset_n = 1'b1;
    tick(1);

    // Idle bus.
    #1;
    check("idle_acc", 32'(accessable), 32'h1);
    check("idle_rdata", rdata, 32'h0);

    // RAM path.
    wr = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    #1;
    check("ram_dm_wr", 32'(dm_wr), 32'h1);
    check("ram_dm_addr", dm_addr, 32'h4);
    check("ram_dm_wdata", dm_wdata, 32'hDEAD_BEEF);
    check("ram_wr_acc", 32'(accessable), 32'h1);
    wr = 1'b0; rd = 1'b1;
    #1;
    check("ram_dm_rd", 32'(dm_rd), 32'h1);
    rd_chk("ram_rd", 32'h10, 32'h1234_5678, 1'b1);
    rd = 1'b1; addr = 32'h400; #1;
    check("oob_dm_rd", 32'(dm_rd), 32'h0);
    rd_chk("oob_rd", 32'h400, 32'h0, 1'b0);
    rd = 1'b1; addr = 32'h12; #1;
    check("mis_dm_rd", 32'(dm_rd), 32'h0);
    rd_chk("mis_rd", 32'h12, 32'h0, 1'b0);
    rd_chk("last_ram", 32'h3FC, 32'h1234_5678, 1'b1);
    dm_accessable = 1'b0;
    rd_chk("ram_dm_bad", 32'h3FC, 32'h1234_5678, 1'b0);
    dm_accessable = 1'b1;
    rd_chk("unmapped", 32'h4000_001C, 32'h0, 1'b0);

    // Timer reload and interrupt.
    wr_reg(32'h4000_0000, 32'hFFFF_FFFD);
    wr_reg(32'h4000_0004, 32'hFFFF_FFFE);
    wr_reg(32'h4000_0008, 32'h3);
    check("tmr_irq0", 32'(irqout), 32'h0);
    rd_chk("tmr_tl0", 32'h4000_0004, 32'hFFFF_FFFE, 1'b1);
    tick(1);
    rd_chk("tmr_tl1", 32'h4000_0004, 32'hFFFF_FFFF, 1'b1);
    tick(1);
    rd_chk("tmr_reload", 32'h4000_0004, 32'hFFFF_FFFD, 1'b1);
    rd_chk("tmr_tcon7", 32'h4000_0008, 32'h7, 1'b1);
    check("tmr_irq1", 32'(irqout), 32'h1);
    wr = 1'b1; addr = 32'h4000_0008; wdata = 32'h3; #1;
    check("tmr_irq_hold", 32'(irqout), 32'h1);
    @(posedge clk); #1; wr = 1'b0;
    check("tmr_irq_clr", 32'(irqout), 32'h0);
    rd_chk("tmr_tl_fe", 32'h4000_0004, 32'hFFFF_FFFE, 1'b1);

    // TCON write coincident with the reload edge keeps the new interrupt.
    tick(1);
    wr_reg(32'h4000_0008, 32'h3);
    rd_chk("coin_tcon", 32'h4000_0008, 32'h7, 1'b1);
    check("coin_irq", 32'(irqout), 32'h1);
    rd_chk("coin_tl", 32'h4000_0004, 32'hFFFF_FFFD, 1'b1);

    // Asynchronous reset between edges.
    reset_n = 1'b0;
    #1;
    check("arst_irq", 32'(irqout), 32'h0);
    rd_chk("arst_tl", 32'h4000_0004, 32'h0, 1'b1);
    rd_chk("arst_tcon", 32'h4000_0008, 32'h0, 1'b1);
    reset_n = 1'b1;
    tick(3);
    rd_chk("arst_tl_hold", 32'h4000_0004, 32'h0, 1'b1);

    // Peripheral registers and ignored writes.
    wr_reg(32'h4000_000C, 32'h1A5);
    rd_chk("led_rd", 32'h4000_000C, 32'hA5, 1'b1);
    check("led_port", 32'(led), 32'hA5);
    wr_reg(32'h4000_0014, 32'hFFFFF);
    rd_chk("digi_rd", 32'h4000_0014, 32'hFFF, 1'b1);
    check("digi_port", 32'(digi), 32'hFFF);
    wr_reg(32'h4000_000D, 32'h0);
    rd_chk("led_mis_wr", 32'h4000_000C, 32'hA5, 1'b1);
    wr_reg(32'h4000_0010, 32'hFF);
    rd_chk("sw_ro", 32'h4000_0010, 32'h5C, 1'b1);

    // systick: write ignored, counts one per cycle.
    rd = 1'b1; addr = 32'h4000_0018; #1;
    s0 = rdata;
    rd = 1'b0; wr = 1'b1; wdata = 32'h0; #1;
    check("tick_wr_acc", 32'(accessable), 32'h1);
    @(posedge clk); #1; wr = 1'b0;
    rd_chk("tick_wr_ign", 32'h4000_0018, s0 + 32'd1, 1'b1);
    rd = 1'b1; addr = 32'h4000_0018; #1;
    s0 = rdata; rd = 1'b0;
    tick(5);
    rd_chk("tick_diff5", 32'h4000_0018, s0 + 32'd5, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
